// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I memory stage with byte-lane steering, load extension,
//            alignment check and bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  instr_id,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    // Instruction IDs as defined in instr_defines.vh
    localparam logic [5:0] c_ID_LB  = 6'd11;
    localparam logic [5:0] c_ID_LH  = 6'd12;
    localparam logic [5:0] c_ID_LW  = 6'd13;
    localparam logic [5:0] c_ID_LBU = 6'd14;
    localparam logic [5:0] c_ID_LHU = 6'd15;
    localparam logic [5:0] c_ID_SB  = 6'd16;
    localparam logic [5:0] c_ID_SH  = 6'd17;
    localparam logic [5:0] c_ID_SW  = 6'd18;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    localparam int unsigned     c_CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_CMAX  = (TIMEOUT > 1) ? c_CW'(TIMEOUT - 1) : '0;
    localparam logic            c_TO_EN = (TIMEOUT != 0);

    logic [0:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_mem_req;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_wstrb;
    logic [4:0]      r_rd;
    logic [1:0]      r_size;
    logic            r_uns;
    logic            r_done;
    logic            r_wb_we;
    logic [4:0]      r_wb_rd;
    logic [31:0]     r_wb_data;
    logic            r_misal;
    logic            r_bus_err;
    logic [31:0]     r_err_addr;

    logic            w_is_mem;
    logic            w_we;
    logic [1:0]      w_size;
    logic            w_uns;
    logic            w_misal;
    logic [3:0]      w_wstrb;
    logic [31:0]     w_wdata;
    logic            w_accept;
    logic            w_expire;
    logic [31:0]     w_shift;
    logic [31:0]     w_load;

    // Decode: size 0 = byte, 1 = halfword, 2 = word
    always_comb begin
        w_is_mem = 1'b1;
        w_we     = 1'b0;
        w_size   = 2'd0;
        w_uns    = 1'b0;
        case (instr_id)
            c_ID_LB:  ;
            c_ID_LH:  w_size = 2'd1;
            c_ID_LW:  w_size = 2'd2;
            c_ID_LBU: w_uns = 1'b1;
            c_ID_LHU: begin w_size = 2'd1; w_uns = 1'b1; end
            c_ID_SB:  w_we = 1'b1;
            c_ID_SH:  begin w_we = 1'b1; w_size = 2'd1; end
            c_ID_SW:  begin w_we = 1'b1; w_size = 2'd2; end
            default:  w_is_mem = 1'b0;
        endcase
    end

    always_comb begin
        w_misal = 1'b0;
        w_wstrb = 4'b0000;
        w_wdata = 32'd0;
        case (w_size)
            2'd1:    w_misal = alu_result[0];
            2'd2:    w_misal = (alu_result[1:0] != 2'b00);
            default: w_misal = 1'b0;
        endcase
        if (w_we) begin
            case (w_size)
                2'd0: begin
                    w_wstrb = 4'b0001 << alu_result[1:0];
                    w_wdata = {4{rs2[7:0]}};
                end
                2'd1: begin
                    w_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{rs2[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = rs2;
                end
            endcase
        end
    end

    always_comb begin
        w_shift = mem_rdata >> {r_addr[1:0], 3'b000};
        case (r_size)
            2'd0:    w_load = r_uns ? {24'd0, w_shift[7:0]}
                                    : {{24{w_shift[7]}}, w_shift[7:0]};
            2'd1:    w_load = r_uns ? {16'd0, w_shift[15:0]}
                                    : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    assign w_accept = in_valid && w_is_mem && (r_state == c_IDLE);
    // Completion takes priority over an expiry landing in the same cycle
    assign w_expire = c_TO_EN && (r_cnt == c_CMAX) && !mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_mem_req  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_rd       <= 5'd0;
            r_size     <= 2'd0;
            r_uns      <= 1'b0;
            r_done     <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
            r_misal    <= 1'b0;
            r_bus_err  <= 1'b0;
            r_err_addr <= 32'd0;
        end else begin
            r_done    <= 1'b0;
            r_wb_we   <= 1'b0;
            r_misal   <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (w_misal) begin
                            r_misal    <= 1'b1;
                            r_err_addr <= alu_result;
                        end else begin
                            r_state   <= c_BUSY;
                            r_cnt     <= '0;
                            r_mem_req <= 1'b1;
                            r_we      <= w_we;
                            r_addr    <= alu_result;
                            r_wdata   <= w_wdata;
                            r_wstrb   <= w_wstrb;
                            r_rd      <= rd;
                            r_size    <= w_size;
                            r_uns     <= w_uns;
                        end
                    end
                end
                c_BUSY: begin
                    if (mem_ready) begin
                        r_state   <= c_IDLE;
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        if (!r_we) begin
                            r_wb_data <= w_load;
                            r_wb_rd   <= r_rd;
                            r_wb_we   <= (r_rd != 5'd0);
                        end
                    end else if (w_expire) begin
                        r_state    <= c_IDLE;
                        r_mem_req  <= 1'b0;
                        r_bus_err  <= 1'b1;
                        r_err_addr <= r_addr;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == c_IDLE);
    assign mem_req    = r_mem_req;
    assign mem_we     = r_we;
    assign mem_addr   = {r_addr[31:2], 2'b00};
    assign mem_wdata  = r_wdata;
    assign mem_wstrb  = r_wstrb;
    assign done       = r_done;
    assign wb_we      = r_wb_we;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign misaligned = r_misal;
    assign bus_err    = r_bus_err;
    assign err_addr   = r_err_addr;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage block directly downstream of the execute ALU. Takes the ALU result as the effective address for RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW). Drives a single-outstanding request/ready data-memory port with byte-lane steering. Returns sign- or zero-extended load data to writeback, and reports misaligned accesses and bus timeouts.

## Interface
- TIMEOUT, 16, max cycles `mem_req` may wait for `mem_ready` before abort; 0 disables the timeout
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents an op this cycle
- in_ready  out  1  unit can accept an op; equals (state==IDLE)
- instr_id  in  6  decoded instruction ID from instr_defines.vh
- alu_result  in  32  effective address (rs1+imm from the ALU)
- rs2  in  32  store data
- rd  in  5  load destination register
- mem_req  out  1  bus request, held until `mem_ready`
- mem_we  out  1  1 = store
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables, 0 for loads
- mem_ready  in  1  bus completes the access this cycle
- mem_rdata  in  32  load word, valid when `mem_ready`
- done  out  1  one-cycle pulse, op completed successfully
- wb_we  out  1  one-cycle pulse, write `wb_data` to `wb_rd`
- wb_rd  out  5  load destination
- wb_data  out  32  extended load result
- misaligned  out  1  one-cycle pulse, access rejected for alignment
- bus_err  out  1  one-cycle pulse, access aborted by timeout
- err_addr  out  32  full byte address of the last misaligned or bus_err op

## Operation
- States:
  - IDLE: accepts new ops.
  - BUSY: request outstanding.
- Memory op accepted in IDLE when `in_valid` and `instr_id` ∈ {LB,LH,LW,LBU,LHU,SB,SH,SW}. Other IDs are ignored: no response, state unchanged.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0; byte is always aligned.
- Misaligned op: no bus access. Next cycle `misaligned`=1 and `err_addr`=addr. State stays IDLE.
- Aligned op: latch the op, addr, lane data and rd; go to BUSY. Outputs are registered:
  - `mem_req`=1 from the next cycle.
  - `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are stable while `mem_req`=1.
- Store lanes:
  - SB: wstrb = 4'b0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = rs2.
- Load extraction: shifted = mem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7 or bit 15 of `shifted`.
  - LBU/LHU zero-extend.
  - LW takes the word unchanged.
- BUSY with `mem_ready`=1: next cycle `mem_req`=0, `done`=1, state IDLE. For loads also `wb_data` valid, `wb_rd`=rd, and `wb_we`=1 only if rd≠0.
- Timeout counter: clears on entry to BUSY and increments each BUSY cycle without `mem_ready`. If TIMEOUT≠0 and the count reaches TIMEOUT−1 without `mem_ready`, then next cycle:
  - `mem_req`=0, `bus_err`=1, `err_addr`=addr, state IDLE.
  - No `done` and no `wb_we`.
- `mem_ready` in IDLE is ignored.
- `mem_ready` in the same cycle the counter expires: completion wins, no `bus_err`.

## Timing
- Reset: state IDLE, timeout counter 0, and all outputs 0 except `in_ready`, which is 1 from the first cycle after reset.
  - Zero outputs: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `done`, `wb_we`, `wb_rd`, `wb_data`, `misaligned`, `bus_err`, `err_addr`.
- Reset during BUSY: the pending op is discarded. `mem_req` is 0 the cycle after the reset edge; no `done`, `wb_we` or `bus_err`.
- Latency: accept at cycle N, `mem_req` at N+1. If `mem_ready` arrives at cycle M (M ≥ N+1), `done`/`wb_we` are high at M+1. Minimum accept→done is 2 cycles.
- Back-to-back: `in_ready`=1 in the cycle `done` is high, so a new op accepted then gives `mem_req` at M+2. Throughput is one op per 2 cycles with zero-wait memory.
- `misaligned` and `bus_err` are single-cycle pulses and never coincide with `done`.
- `wb_data` and `wb_rd` hold their values until the next load completes.

## Test plan
- LW at 0x0000_1004, `mem_ready` in the first request cycle with rdata 0xDEADBEEF:
  - `mem_addr` 0x00001004, wstrb 0.
  - Two cycles after accept: `done`=1, `wb_we`=1, `wb_data` 0xDEADBEEF.
- LB at 0x1003 with rdata 0x80FF_0000 gives 0xFFFFFF80; LBU on the same access gives 0x00000080; LH at 0x1002 gives 0xFFFF80FF; LH with rd=0 gives `done`=1 and `wb_we`=0.
- SB at 0x2002 with rs2 0x12345678: wstrb 0100, wdata 0x78787878. SH at 0x2002: wstrb 1100, wdata 0x56785678. Stores give `done` pulse and `wb_we`=0.
- LW at 0x3001: no `mem_req`; next cycle `misaligned`=1, `err_addr` 0x3001, `in_ready` stays 1.
- TIMEOUT=16 with `mem_ready` held 0: `bus_err`=1 one cycle after the 16th request cycle, `mem_req` drops, `in_ready` returns. A second run with `mem_ready` asserted on the 16th cycle gives `done` and no `bus_err`.
- Reset asserted while BUSY: `mem_req`=0 next cycle and no `done`. A following LW completes normally.
